// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its scoreboard.
// Latency: none (types, constants and a mask helper only).
// Backpressure: none.
// Contents: register address width and count, the zero-register id, the
// starve counter width, the arbiter state encoding and a one-hot mask helper.
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Wide enough for the largest supported starvation limit (15).
  localparam int STARVE_W = 4;

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_e;

  // One-hot mask selecting a single register.
  function automatic logic [REG_COUNT-1:0] reg_mask(input logic [REG_ADDR_W-1:0] idx);
    logic [REG_COUNT-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of all writeback, issue, hazard-check and register-file signals.
// Latency: none (wiring only).
// Backpressure: a_ready/b_ready are driven by the arbiter (slave side).
// Ports: master = sources and decode (drive valid/rd/data/issue/chk),
//        slave  = arbiter (drives ready, busy flags and the register-file write).
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int N = 32
) ();

  logic                  a_valid;
  logic [REG_ADDR_W-1:0] a_rd;
  logic [N-1:0]          a_data;
  logic                  a_ready;

  logic                  b_valid;
  logic [REG_ADDR_W-1:0] b_rd;
  logic [N-1:0]          b_data;
  logic                  b_ready;

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;

  logic [REG_ADDR_W-1:0] chk_rs1;
  logic [REG_ADDR_W-1:0] chk_rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [N-1:0]          rf_wdata;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output issue_valid, issue_rd,
    output chk_rs1, chk_rs2,
    input  a_ready, b_ready,
    input  rs1_busy, rs2_busy,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  issue_valid, issue_rd,
    input  chk_rs1, chk_rs2,
    output a_ready, b_ready,
    output rs1_busy, rs2_busy,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Busy bit per register for destinations with an outstanding long-latency result.
// Latency: set/clear visible on the read ports one cycle later; reads are combinational.
// Backpressure: none; set and clear are accepted every cycle.
// Ports: clk, rst (sync active-low), set_vld_i/set_idx_i (issue),
//        clr_vld_i/clr_idx_i (B grant), rd0/rd1_idx_i -> rd0/rd1_busy_o.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_vld_i,
  input  logic [REG_ADDR_W-1:0] set_idx_i,
  input  logic                  clr_vld_i,
  input  logic [REG_ADDR_W-1:0] clr_idx_i,
  input  logic [REG_ADDR_W-1:0] rd0_idx_i,
  input  logic [REG_ADDR_W-1:0] rd1_idx_i,
  output logic                  rd0_busy_o,
  output logic                  rd1_busy_o
);

  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [REG_COUNT-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_vld_i && (set_idx_i != ZERO_REG)) set_mask = reg_mask(set_idx_i);
    if (clr_vld_i) clr_mask = reg_mask(clr_idx_i);
    // Set is applied after clear so a same-cycle re-issue keeps the register busy.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign rd0_busy_o = busy_q[rd0_idx_i];
  assign rd1_busy_o = busy_q[rd1_idx_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline (A) and long-latency (B) writeback.
// Latency: a grant in cycle T drives rf_we/rf_waddr/rf_wdata in cycle T+1; readies are combinational.
// Backpressure: A has priority; B is forced through after STARVE_MAX consecutive denied cycles.
// Ports: clk, rst (sync active-low), bus (slave modport: A/B writeback handshakes,
//        issue tracking, decode hazard checks, register-file write outputs).
module rf_wb_arbiter #(
  parameter int N          = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  import rf_wb_arbiter_pkg::*;

  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

  arb_state_e            state_q, state_d;
  logic [STARVE_W-1:0]   starve_q, starve_d, starve_inc;
  logic                  starve_hit;

  logic                  a_rdy, b_rdy;
  logic                  a_grant, b_grant;

  logic                  wr_vld;
  logic [REG_ADDR_W-1:0] wr_rd;
  logic [N-1:0]          wr_data;

  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [N-1:0]          rf_wdata_q;

  logic                  rs1_busy, rs2_busy;

  // State register and starve counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next state. The force is taken in the cycle whose denial would bring the
  // count up to STARVE_MAX, so B wins on the following cycle.
  always_comb begin
    starve_inc = starve_q + 1'b1;
    starve_hit = (state_q == NORMAL) && bus.b_valid && !b_rdy &&
                 (starve_inc == STARVE_MAX_C);

    starve_d = '0;
    if (bus.b_valid && !b_rdy && !starve_hit) starve_d = starve_inc;

    state_d = NORMAL;
    case (state_q)
      NORMAL:  state_d = starve_hit ? FORCE_B : NORMAL;
      FORCE_B: state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // Output decode: readies held low while reset is asserted.
  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    if (rst) begin
      case (state_q)
        NORMAL: begin
          a_rdy = bus.a_valid;
          b_rdy = bus.b_valid && !bus.a_valid;
        end
        FORCE_B: begin
          b_rdy = bus.b_valid;
        end
        default: begin
          a_rdy = 1'b0;
          b_rdy = 1'b0;
        end
      endcase
    end
  end

  assign a_grant = bus.a_valid && a_rdy;
  assign b_grant = bus.b_valid && b_rdy;

  // At most one grant per cycle, so a simple priority mux selects it.
  assign wr_vld  = a_grant || b_grant;
  assign wr_rd   = a_grant ? bus.a_rd   : bus.b_rd;
  assign wr_data = a_grant ? bus.a_data : bus.b_data;

  // Writes to x0 are accepted upstream but never reach the register file.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= wr_vld && (wr_rd != ZERO_REG);
      if (wr_vld && (wr_rd != ZERO_REG)) begin
        rf_waddr_q <= wr_rd;
        rf_wdata_q <= wr_data;
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_vld_i  (bus.issue_valid),
    .set_idx_i  (bus.issue_rd),
    .clr_vld_i  (b_grant),
    .clr_idx_i  (bus.b_rd),
    .rd0_idx_i  (bus.chk_rs1),
    .rd1_idx_i  (bus.chk_rs2),
    .rd0_busy_o (rs1_busy),
    .rd1_busy_o (rs2_busy)
  );

  assign bus.a_ready  = a_rdy;
  assign bus.b_ready  = b_rdy;
  assign bus.rs1_busy = rs1_busy;
  assign bus.rs2_busy = rs2_busy;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, A path, starvation, scoreboard, x0, mid-stream reset.
// Timing: inputs change 2 time units after a rising edge, outputs are checked 1 unit later.
// Backpressure: sources hold valid until the readies show a grant.
module tb_rf_wb_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rf_wb_arbiter_if #(.N(32)) bus ();

  rf_wb_arbiter #(.N(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.a_valid     = 1'b0;
    bus.a_rd        = 5'd0;
    bus.a_data      = 32'd0;
    bus.b_valid     = 1'b0;
    bus.b_rd        = 5'd0;
    bus.b_data      = 32'd0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    idle();
    bus.chk_rs1 = 5'd0;
    bus.chk_rs2 = 5'd0;

    // Reset hold with both sources requesting and an issue attempt.
    tick();
    bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 32'h11;
    bus.b_valid = 1'b1; bus.b_rd = 5'd2; bus.b_data = 32'h22;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_a_ready", 32'(bus.a_ready), 32'd0);
      check("rst_b_ready", 32'(bus.b_ready), 32'd0);
      check("rst_rf_we",   32'(bus.rf_we),   32'd0);
      tick();
    end
    rst = 1'b1;
    idle();
    #1;
    check("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_rf_wdata", bus.rf_wdata, 32'd0);
    // Every scoreboard entry must read clear after reset.
    for (int r = 0; r < 32; r++) begin
      tick();
      bus.chk_rs1 = 5'(r);
      #1;
      check("rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
      check("idle_rf_we",   32'(bus.rf_we),    32'd0);
    end

    // Single A write.
    tick();
    bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEADBEEF;
    #1;
    check("a_single_ready", 32'(bus.a_ready), 32'd1);
    check("a_single_bready", 32'(bus.b_ready), 32'd0);
    tick();
    idle();
    #1;
    check("a_single_we",    32'(bus.rf_we),    32'd1);
    check("a_single_waddr", 32'(bus.rf_waddr), 32'd5);
    check("a_single_wdata", bus.rf_wdata,      32'hDEADBEEF);
    tick();
    #1;
    check("a_single_we_off", 32'(bus.rf_we), 32'd0);

    // Contention: B wins every fifth cycle.
    tick();
    bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 32'hAAAA0001;
    bus.b_valid = 1'b1; bus.b_rd = 5'd2; bus.b_data = 32'hBBBB0002;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("cont_a_ready", 32'(bus.a_ready), ((k % 5) != 4) ? 32'd1 : 32'd0);
      check("cont_b_ready", 32'(bus.b_ready), ((k % 5) == 4) ? 32'd1 : 32'd0);
      if (k > 0) begin
        check("cont_rf_we",    32'(bus.rf_we),    32'd1);
        check("cont_rf_waddr", 32'(bus.rf_waddr), (((k - 1) % 5) == 4) ? 32'd2 : 32'd1);
      end
      tick();
    end
    idle();
    #1;
    check("cont_last_waddr", 32'(bus.rf_waddr), 32'd2);
    check("cont_last_wdata", bus.rf_wdata,      32'hBBBB0002);

    // Scoreboard: issue to r7, clear via B grant.
    tick();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.chk_rs1 = 5'd7;
    #1;
    check("sb7_not_yet", 32'(bus.rs1_busy), 32'd0);
    tick();
    bus.issue_valid = 1'b0;
    #1;
    check("sb7_busy", 32'(bus.rs1_busy), 32'd1);
    tick();
    #1;
    check("sb7_still_busy", 32'(bus.rs1_busy), 32'd1);
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'h00C0FFEE;
    #1;
    check("sb7_b_ready", 32'(bus.b_ready), 32'd1);
    check("sb7_busy_grant_cycle", 32'(bus.rs1_busy), 32'd1);
    tick();
    idle();
    #1;
    check("sb7_cleared", 32'(bus.rs1_busy), 32'd0);
    check("sb7_rf_we",   32'(bus.rf_we),    32'd1);
    check("sb7_rf_waddr", 32'(bus.rf_waddr), 32'd7);
    check("sb7_rf_wdata", bus.rf_wdata,      32'h00C0FFEE);

    // Scoreboard: same-cycle set and clear on r9 keeps it busy.
    tick();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.chk_rs2 = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    #1;
    check("sb9_busy", 32'(bus.rs2_busy), 32'd1);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h9;
    #1;
    check("sb9_b_ready", 32'(bus.b_ready), 32'd1);
    tick();
    idle();
    #1;
    check("sb9_set_wins", 32'(bus.rs2_busy), 32'd1);

    // x0 handling.
    tick();
    bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'h1234;
    #1;
    check("x0_a_ready", 32'(bus.a_ready), 32'd1);
    tick();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.chk_rs1 = 5'd0;
    #1;
    check("x0_rf_we", 32'(bus.rf_we), 32'd0);
    tick();
    idle();
    #1;
    check("x0_rs1_busy", 32'(bus.rs1_busy), 32'd0);

    // Reset in the cycle B would be forced through, with r3 busy.
    tick();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; bus.chk_rs1 = 5'd3;
    tick();
    idle();
    #1;
    check("mid_r3_busy", 32'(bus.rs1_busy), 32'd1);
    bus.a_valid = 1'b1; bus.a_rd = 5'd4; bus.a_data = 32'h44;
    bus.b_valid = 1'b1; bus.b_rd = 5'd3; bus.b_data = 32'h33;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("mid_a_ready", 32'(bus.a_ready), 32'd1);
      tick();
    end
    rst = 1'b0;
    #1;
    check("mid_rst_b_ready", 32'(bus.b_ready), 32'd0);
    check("mid_rst_a_ready", 32'(bus.a_ready), 32'd0);
    tick();
    rst = 1'b1;
    idle();
    #1;
    check("mid_rf_we_rst",  32'(bus.rf_we),    32'd0);
    check("mid_r3_cleared", 32'(bus.rs1_busy), 32'd0);
    bus.chk_rs2 = 5'd9;
    #1;
    check("mid_r9_cleared", 32'(bus.rs2_busy), 32'd0);
    tick();
    #1;
    check("mid_rf_we_rel", 32'(bus.rf_we), 32'd0);
    bus.a_valid = 1'b1; bus.a_rd = 5'd4; bus.a_data = 32'h44;
    bus.b_valid = 1'b1; bus.b_rd = 5'd3; bus.b_data = 32'h33;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("post_a_ready", 32'(bus.a_ready), (k != 4) ? 32'd1 : 32'd0);
      check("post_b_ready", 32'(bus.b_ready), (k == 4) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
- Source A is the main pipeline writeback. Source B is a long-latency unit (load/multi-cycle ALU).
- Keeps a busy scoreboard of destination registers with an outstanding B result, so decode can stall on RAW hazards.
- Sits between the writeback stage / long-latency unit and the register file write inputs (regWrite, WriteReg, WrData).

Parameters:
- N, 32, data width of the register file
- STARVE_MAX, 4, consecutive denied cycles of B before B is forced to win one grant (range 1..15)

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-low reset
- a_valid  in  1  source A has a result
- a_rd  in  5  source A destination register
- a_data  in  N  source A result
- a_ready  out  1  source A granted this cycle (combinational)
- b_valid  in  1  source B has a result
- b_rd  in  5  source B destination register
- b_data  in  N  source B result
- b_ready  out  1  source B granted this cycle (combinational)
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  destination of the issued op
- chk_rs1  in  5  decode source register 1
- chk_rs2  in  5  decode source register 2
- rs1_busy  out  1  chk_rs1 has a pending B result (combinational)
- rs2_busy  out  1  chk_rs2 has a pending B result (combinational)
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  5  register file write address (registered)
- rf_wdata  out  N  register file write data (registered)

Behaviour:
- Reset (rst==0 at posedge):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Scoreboard busy[31:0]=0, starve counter=0, FSM=NORMAL.
  - a_ready=b_ready=0 while rst==0.
- Handshake: a transfer occurs when valid && ready in the same cycle. Sources hold valid/rd/data stable until granted.
- FSM has two states.
  - NORMAL: A has fixed priority.
    - a_ready = a_valid.
    - b_ready = b_valid && !a_valid.
  - FORCE_B:
    - b_ready = b_valid, a_ready = 0.
    - Next state is always NORMAL.
- Starve counter:
  - Increments when b_valid && !b_ready.
  - Cleared on a B grant or when b_valid==0.
  - When the counter reaches STARVE_MAX in NORMAL, next state is FORCE_B and the counter clears.
- Write latency: 1 cycle. A grant at cycle T gives rf_we=1 with the granted rd/data at T+1. With no grant at T, rf_we=0 at T+1.
- x0 writes: a grant with rd==0 is accepted (ready asserted) but produces rf_we=0 at T+1.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd].
  - A B grant clears busy[b_rd].
  - Both set and clear on the same register in one cycle: set wins.
  - busy[0] is constant 0.
  - Issuing to an already-busy register leaves it busy.
- rsN_busy = busy[chk_rsN], combinational. Clearing takes effect the cycle after the grant, aligned with rf_we.
- A grant never affects the scoreboard.
- Mid-operation reset discards any pending grant; rf_we is 0 in the cycle after reset deasserts unless a new grant occurs.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5
  - REG_COUNT=32
  - ZERO_REG=5'd0
  - FSM state encoding (NORMAL=1'b0, FORCE_B=1'b1)
- One natural sub-module, rf_scoreboard: 32-bit busy vector with set/clear ports and two read ports. Arbiter FSM, starve counter and output register stay in the top.

Test Plan:
- Reset hold: drive rst=0 with a_valid=1, b_valid=1 for 3 cycles -> a_ready=b_ready=0, rf_we=0, rs1_busy=0 for every chk_rs1.
- Single A: a_valid=1, a_rd=5, a_data=32'hDEADBEEF at T -> a_ready=1 at T; rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF at T+1; rf_we=0 at T+2.
- Contention/starvation, STARVE_MAX=4: a_valid and b_valid both held high -> A granted 4 cycles, B granted on the 5th (a_ready=0), then A again; B wins every 5th cycle.
- Scoreboard: issue_valid=1, issue_rd=7; chk_rs1=7 -> rs1_busy=1 from the next cycle until the cycle after a B grant with b_rd=7, then 0. Set and clear of reg 9 in the same cycle -> busy[9] stays 1.
- x0 handling: a_valid=1, a_rd=0 -> a_ready=1, rf_we=0 next cycle. issue_rd=0 -> rs1_busy stays 0 for chk_rs1=0.
- Reset mid-stream: assert rst=0 in the cycle a B grant occurs with busy[3]=1 -> after release, rf_we=0, busy all 0, counter 0, FSM NORMAL.
